// File: rtl/amba_axi_pkg.sv
// AXI slave request/response bundles and response codes shared by CSR-mapped blocks.
package amba_axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t AXI_OKAY   = 2'b00;
  localparam axi_resp_t AXI_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic                  aw_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic                  w_valid;
    logic                  b_ready;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic                  ar_valid;
    logic                  r_ready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_ID_W-1:0]   b_id;
    axi_resp_t             b_resp;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    axi_resp_t             r_resp;
    logic                  r_last;
    logic                  r_valid;
  } s_axi_miso_t;

endpackage

// File: rtl/irq_ctrl_pkg.sv
// CSR map, status bit positions and source type encoding for the IRQ controller.
package irq_ctrl_pkg;

  typedef enum logic {LEVEL = 1'b0, EDGE = 1'b1} irq_type_t;

  localparam logic [15:0] CSR_ID      = 16'h00;
  localparam logic [15:0] CSR_MASK_LO = 16'h04;
  localparam logic [15:0] CSR_MASK_HI = 16'h08;
  localparam logic [15:0] CSR_TYPE_LO = 16'h0C;
  localparam logic [15:0] CSR_TYPE_HI = 16'h10;
  localparam logic [15:0] CSR_PEND_LO = 16'h14;
  localparam logic [15:0] CSR_PEND_HI = 16'h18;
  localparam logic [15:0] CSR_CLEAR   = 16'h1C;
  localparam logic [15:0] CSR_STATUS  = 16'h20;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_OCC_LSB = 8;

  localparam logic [31:0] ID_EMPTY = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: runtime level/edge type, registered edge detect, pending and in-service state.
module irq_src_cell
  import irq_ctrl_pkg::*;
#(
  parameter irq_type_t TYPE_RST = LEVEL
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      irq,
  input  logic      type_wr,
  input  logic      type_wdata,
  input  logic      push_hit,
  input  logic      pop_hit,
  input  logic      fifo_clr,
  output irq_type_t src_type,
  output logic      pending,
  output logic      in_service,
  output logic      coalesce
);
  logic irq_q, edge_pend, rise;

  assign rise = irq && !irq_q && (src_type == EDGE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q      <= 1'b0;
      edge_pend  <= 1'b0;
      in_service <= 1'b0;
      src_type   <= TYPE_RST;
    end else begin
      irq_q <= irq;
      if (type_wr) src_type <= irq_type_t'(type_wdata);
      // a fresh edge beats a same-cycle clear so it is never dropped
      if (rise)                     edge_pend <= 1'b1;
      else if (push_hit || type_wr) edge_pend <= 1'b0;
      if (push_hit)                 in_service <= 1'b1;
      else if (pop_hit || fifo_clr) in_service <= 1'b0;
    end
  end

  assign pending  = (src_type == EDGE) ? edge_pend : irq_q;
  assign coalesce = rise && edge_pend && !push_hit && !type_wr;

endmodule

// File: rtl/sync_gp_fifo.sv
// Single-clock FIFO with wrap-bit pointers; storage is not reset, only pointers are.
module sync_gp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/axi_irq_ctrl_mc.sv
// Fixed-priority IRQ controller: sources feed an ID log FIFO popped through an AXI CSR slave.
module axi_irq_ctrl_mc
  import amba_axi_pkg::*;
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int          N_IRQ         = 32,
  parameter logic [63:0] TYPE_OF_IRQ   = 64'h0,
  parameter int          DEPTH_OF_FIFO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_summary_o,
  input  s_axi_mosi_t      axi_mosi,
  output s_axi_miso_t      axi_miso
);
  localparam int IDW  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int CNTW = $clog2(DEPTH_OF_FIFO) + 1;

  logic [N_IRQ-1:0] mask_q, type_vec, pending, in_service, coalesce, elig, push_vec, pop_vec;
  logic [63:0]      mask64, type64, pend64;
  logic             ovf_q;
  logic             fifo_clr, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [IDW-1:0]   grant_id, head_id;
  logic [CNTW-1:0]  fifo_cnt;
  logic [31:0]      status_word, rd_data;

  logic                aw_ready_q, w_ready_q, b_valid_q, ar_ready_q, r_valid_q, r_pop_q;
  logic                aw_hs, w_hs, ar_hs, r_hs, b_hs;
  logic [15:0]         aw_addr_q, wr_addr, wr_off, rd_off;
  logic [AXI_ID_W-1:0] aw_id_q, b_id_q, r_id_q;
  axi_resp_t           b_resp_q, r_resp_q;
  logic [31:0]         r_data_q;
  logic                wr_err, rd_err;
  logic                wr_mask_lo, wr_mask_hi, wr_type_lo, wr_type_hi, wr_status;
  logic                unused_mosi;

  assign unused_mosi = ^{axi_mosi.aw_addr[31:16], axi_mosi.ar_addr[31:16], axi_mosi.w_data};

  assign aw_hs   = axi_mosi.aw_valid && aw_ready_q;
  assign w_hs    = axi_mosi.w_valid && w_ready_q && (aw_hs || !aw_ready_q);
  assign b_hs    = b_valid_q && axi_mosi.b_ready;
  assign ar_hs   = axi_mosi.ar_valid && ar_ready_q;
  assign r_hs    = r_valid_q && axi_mosi.r_ready;
  assign wr_addr = aw_hs ? axi_mosi.aw_addr[15:0] : aw_addr_q;
  assign wr_off  = wr_addr - BASE_ADDR[15:0];
  assign rd_off  = axi_mosi.ar_addr[15:0] - BASE_ADDR[15:0];

  always_comb begin
    wr_err = 1'b0; wr_mask_lo = 1'b0; wr_mask_hi = 1'b0;
    wr_type_lo = 1'b0; wr_type_hi = 1'b0; wr_status = 1'b0; fifo_clr = 1'b0;
    case (wr_off)
      CSR_MASK_LO: wr_mask_lo = w_hs;
      CSR_MASK_HI: wr_mask_hi = w_hs;
      CSR_TYPE_LO: wr_type_lo = w_hs;
      CSR_TYPE_HI: wr_type_hi = w_hs;
      CSR_CLEAR:   fifo_clr   = w_hs;
      CSR_STATUS:  wr_status  = w_hs;
      default:     wr_err     = 1'b1;
    endcase
  end

  assign mask64      = 64'(mask_q);
  assign type64      = 64'(type_vec);
  assign pend64      = 64'(pending);
  assign status_word = {15'd0, 9'(fifo_cnt), 5'd0, ovf_q, fifo_full, fifo_empty};

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_off)
      CSR_ID:      rd_data = fifo_empty ? ID_EMPTY : 32'(head_id);
      CSR_MASK_LO: rd_data = mask64[31:0];
      CSR_MASK_HI: rd_data = mask64[63:32];
      CSR_TYPE_LO: rd_data = type64[31:0];
      CSR_TYPE_HI: rd_data = type64[63:32];
      CSR_PEND_LO: rd_data = pend64[31:0];
      CSR_PEND_HI: rd_data = pend64[63:32];
      CSR_STATUS:  rd_data = status_word;
      default:     rd_err  = 1'b1;
    endcase
  end

  // Handshake state: one outstanding write and one outstanding read at a time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_pop_q    <= 1'b0;
    end else begin
      if (aw_hs) aw_ready_q <= 1'b0;
      if (w_hs) begin
        w_ready_q <= 1'b0;
        b_valid_q <= 1'b1;
      end
      if (b_hs) begin
        b_valid_q  <= 1'b0;
        aw_ready_q <= 1'b1;
        w_ready_q  <= 1'b1;
      end
      if (ar_hs) begin
        ar_ready_q <= 1'b0;
        r_valid_q  <= 1'b1;
        r_pop_q    <= (rd_off == CSR_ID) && !fifo_empty;
      end
      if (r_hs) begin
        ar_ready_q <= 1'b1;
        r_valid_q  <= 1'b0;
        r_pop_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_addr_q <= axi_mosi.aw_addr[15:0];
      aw_id_q   <= axi_mosi.aw_id;
    end
    if (w_hs) begin
      b_id_q   <= aw_hs ? axi_mosi.aw_id : aw_id_q;
      b_resp_q <= wr_err ? AXI_SLVERR : AXI_OKAY;
    end
    if (ar_hs) begin
      r_id_q   <= axi_mosi.ar_id;
      r_data_q <= rd_data;
      r_resp_q <= rd_err ? AXI_SLVERR : AXI_OKAY;
    end
  end

  always_comb begin
    axi_miso          = '0;
    axi_miso.aw_ready = aw_ready_q;
    axi_miso.w_ready  = w_ready_q;
    axi_miso.b_valid  = b_valid_q;
    axi_miso.b_id     = b_id_q;
    axi_miso.b_resp   = b_resp_q;
    axi_miso.ar_ready = ar_ready_q;
    axi_miso.r_valid  = r_valid_q;
    axi_miso.r_last   = r_valid_q;
    axi_miso.r_id     = r_id_q;
    axi_miso.r_data   = r_data_q;
    axi_miso.r_resp   = r_resp_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '1;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_IRQ; i++) begin
        if ((i < 32) ? wr_mask_lo : wr_mask_hi) mask_q[i] <= axi_mosi.w_data[i % 32];
      end
      if (|coalesce)                              ovf_q <= 1'b1;
      else if (wr_status && axi_mosi.w_data[ST_OVF]) ovf_q <= 1'b0;
    end
  end

  // Arbiter sees only registered source state; index 0 wins, a clear suppresses the push
  assign elig      = pending & mask_q & ~in_service;
  assign fifo_push = (|elig) && !fifo_full && !fifo_clr;
  assign push_vec  = fifo_push ? (elig & (~elig + N_IRQ'(1))) : '0;
  assign fifo_pop  = r_hs && r_pop_q && !fifo_empty && !fifo_clr;

  always_comb begin
    grant_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) grant_id = IDW'(i);
    end
  end

  always_comb begin
    pop_vec = '0;
    for (int i = 0; i < N_IRQ; i++) pop_vec[i] = fifo_pop && (head_id == IDW'(i));
  end

  for (genvar g = 0; g < N_IRQ; g++) begin : g_src
    irq_src_cell #(.TYPE_RST(irq_type_t'(TYPE_OF_IRQ[g]))) u_cell (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq_i[g]),
      .type_wr    ((g < 32) ? wr_type_lo : wr_type_hi),
      .type_wdata (axi_mosi.w_data[g % 32]),
      .push_hit   (push_vec[g]),
      .pop_hit    (pop_vec[g]),
      .fifo_clr   (fifo_clr),
      .src_type   (type_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g]),
      .coalesce   (coalesce[g])
    );
  end

  sync_gp_fifo #(.DATA_W(IDW), .DEPTH(DEPTH_OF_FIFO)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (grant_id),
    .pop       (fifo_pop),
    .pop_data  (head_id),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

  assign irq_summary_o = !fifo_empty;

endmodule

// File: tb/tb_axi_irq_ctrl_mc.sv
// Bench for axi_irq_ctrl_mc: a depth-8 and a depth-2 instance, expected pop IDs kept in a queue.
module tb_axi_irq_ctrl_mc;
  import amba_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq0, irq1;
  logic        sum0, sum1;
  s_axi_mosi_t mosi [2];
  s_axi_miso_t miso [2];

  int          n_tests, n_fail;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  axi_irq_ctrl_mc #(.N_IRQ(32), .DEPTH_OF_FIFO(8)) dut0 (
    .clk(clk), .rst(rst_n), .irq_i(irq0), .irq_summary_o(sum0),
    .axi_mosi(mosi[0]), .axi_miso(miso[0]));

  axi_irq_ctrl_mc #(.N_IRQ(32), .DEPTH_OF_FIFO(2)) dut1 (
    .clk(clk), .rst(rst_n), .irq_i(irq1), .irq_summary_o(sum1),
    .axi_mosi(mosi[1]), .axi_miso(miso[1]));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input int s, input logic [31:0] a,
                          output logic [31:0] d, output logic [1:0] r);
    int cnt;
    mosi[s].ar_valid = 1'b1;
    mosi[s].ar_addr  = a;
    mosi[s].ar_id    = 4'h5;
    cnt = 0;
    while (!miso[s].ar_ready && cnt < 20) begin tick(1); cnt++; end
    tick(1);
    mosi[s].ar_valid = 1'b0;
    mosi[s].r_ready  = 1'b1;
    cnt = 0;
    while (!miso[s].r_valid && cnt < 20) begin tick(1); cnt++; end
    if (!miso[s].r_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rd_timeout: addr %h got no rvalid, required rvalid", a);
    end
    d = miso[s].r_data;
    r = miso[s].r_resp;
    tick(1);
    mosi[s].r_ready = 1'b0;
  endtask

  task automatic axi_write(input int s, input logic [31:0] a, input logic [31:0] d,
                           output logic [1:0] r);
    int cnt;
    mosi[s].aw_valid = 1'b1;
    mosi[s].aw_addr  = a;
    mosi[s].aw_id    = 4'h9;
    mosi[s].w_valid  = 1'b1;
    mosi[s].w_data   = d;
    mosi[s].b_ready  = 1'b1;
    cnt = 0;
    while (!(miso[s].aw_ready && miso[s].w_ready) && cnt < 20) begin tick(1); cnt++; end
    tick(1);
    mosi[s].aw_valid = 1'b0;
    mosi[s].w_valid  = 1'b0;
    cnt = 0;
    while (!miso[s].b_valid && cnt < 20) begin tick(1); cnt++; end
    if (!miso[s].b_valid) begin
      n_tests++; n_fail++;
      $display("FAIL wr_timeout: addr %h got no bvalid, required bvalid", a);
    end
    r = miso[s].b_resp;
    tick(1);
    mosi[s].b_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [5:0]  ctl;
    rst_n = 1'b0;
    irq0 = '0; irq1 = '0;
    mosi[0] = '0; mosi[1] = '0;
    tick(3);
    ctl = {miso[0].aw_ready, miso[0].w_ready, miso[0].ar_ready,
           miso[0].b_valid, miso[0].r_valid, sum0};
    n_tests++;
    if (ctl !== 6'b111000) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl, 6'b111000); end
    rst_n = 1'b1;
    tick(2);
    axi_read(0, 32'h00, d, r);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_id: got %h want ffffffff", d); end
    n_tests++;
    if (r !== AXI_OKAY) begin n_fail++; $display("FAIL rst_id_resp: got %0d want %0d", r, AXI_OKAY); end
    axi_read(0, 32'h04, d, r);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_mask_lo: got %h want ffffffff", d); end
    axi_read(0, 32'h08, d, r);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mask_hi: got %h want 0", d); end
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL rst_status: got %h want 1", d); end
    axi_read(1, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL rst_status1: got %h want 1", d); end
  endtask

  task automatic test_level();
    logic [31:0] d, e;
    logic [1:0]  r;
    irq0[5] = 1'b1;
    exp_q.push_back(32'd5);
    tick(20);
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h100) begin n_fail++; $display("FAIL lvl_occ: got %h want 100", d); end
    n_tests++;
    if (sum0 !== 1'b1) begin n_fail++; $display("FAIL lvl_summary: got %b want 1", sum0); end
    axi_read(0, 32'h00, d, r);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL lvl_pop: got %h want %h", d, e); end
    tick(1);
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h100) begin n_fail++; $display("FAIL lvl_repush: got %h want 100", d); end
    irq0[5] = 1'b0;
    exp_q.push_back(32'd5);
    tick(2);
    axi_read(0, 32'h00, d, r);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL lvl_pop2: got %h want %h", d, e); end
    tick(2);
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL lvl_drained: got %h want 1", d); end
  endtask

  task automatic test_edge();
    logic [31:0] d, e;
    logic [1:0]  r;
    axi_write(0, 32'h0C, 32'h0000_000A, r);
    n_tests++;
    if (r !== AXI_OKAY) begin n_fail++; $display("FAIL edge_type_wr: got %0d want %0d", r, AXI_OKAY); end
    axi_read(0, 32'h0C, d, r);
    n_tests++;
    if (d !== 32'hA) begin n_fail++; $display("FAIL edge_type_rd: got %h want a", d); end
    irq0[1] = 1'b1;
    irq0[3] = 1'b1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'hFFFF_FFFF);
    tick(4);
    for (int k = 0; k < 3; k++) begin
      axi_read(0, 32'h00, d, r);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL edge_pop%0d: got %h want %h", k, d, e); end
    end
    irq0[1] = 1'b0;
    irq0[3] = 1'b0;
    tick(1);
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    logic [1:0]  r;
    axi_write(1, 32'h0C, 32'h0000_000F, r);
    irq1[3:0] = 4'hF;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    exp_q.push_back(32'hFFFF_FFFF);
    tick(4);
    axi_read(1, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h202) begin n_fail++; $display("FAIL ovf_full: got %h want 202", d); end
    irq1[2] = 1'b0;
    tick(2);
    irq1[2] = 1'b1;
    tick(2);
    axi_read(1, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h206) begin n_fail++; $display("FAIL ovf_sticky: got %h want 206", d); end
    for (int k = 0; k < 5; k++) begin
      axi_read(1, 32'h00, d, r);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", k, d, e); end
    end
    axi_read(1, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL ovf_drained: got %h want 5", d); end
    axi_write(1, 32'h20, 32'h4, r);
    axi_read(1, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ovf_w1c: got %h want 1", d); end
    irq1 = '0;
    tick(1);
  endtask

  task automatic test_mask();
    logic [31:0] d, e;
    logic [1:0]  r;
    axi_write(0, 32'h04, 32'h0, r);
    irq0[7] = 1'b1;
    tick(3);
    axi_read(0, 32'h14, d, r);
    n_tests++;
    if (d !== 32'h80) begin n_fail++; $display("FAIL mask_pend: got %h want 80", d); end
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL mask_noid: got %h want 1", d); end
    axi_write(0, 32'h04, 32'h80, r);
    n_tests++;
    if (sum0 !== 1'b1) begin n_fail++; $display("FAIL mask_unmask: got %b want 1", sum0); end
    irq0[7] = 1'b0;
    exp_q.push_back(32'd7);
    tick(2);
    axi_read(0, 32'h00, d, r);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL mask_pop: got %h want %h", d, e); end
    axi_write(0, 32'h04, 32'hFFFF_FFFF, r);
  endtask

  task automatic test_clear();
    logic [31:0] d, e;
    logic [1:0]  r;
    irq0[10:8] = 3'b111;
    tick(6);
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h300) begin n_fail++; $display("FAIL clr_occ: got %h want 300", d); end
    irq0[10:8] = 3'b000;
    tick(2);
    axi_write(0, 32'h1C, 32'h1234_5678, r);
    n_tests++;
    if (sum0 !== 1'b0) begin n_fail++; $display("FAIL clr_summary: got %b want 0", sum0); end
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL clr_status: got %h want 1", d); end
    axi_read(0, 32'h40, d, r);
    n_tests++;
    if (r !== AXI_SLVERR || d !== 32'h0) begin
      n_fail++; $display("FAIL bad_rd: got resp %0d data %h want resp %0d data 0", r, d, AXI_SLVERR);
    end
    irq0[12] = 1'b1;
    tick(4);
    irq0[12] = 1'b0;
    exp_q.push_back(32'd12);
    tick(2);
    axi_write(0, 32'h00, 32'h0, r);
    n_tests++;
    if (r !== AXI_SLVERR) begin n_fail++; $display("FAIL bad_wr: got %0d want %0d", r, AXI_SLVERR); end
    axi_read(0, 32'h20, d, r);
    n_tests++;
    if (d !== 32'h100) begin n_fail++; $display("FAIL bad_wr_fifo: got %h want 100", d); end
    axi_read(0, 32'h00, d, r);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL clr_pop: got %h want %h", d, e); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_level();
    test_edge();
    test_overflow();
    test_mask();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
